// File: rtl/echo_mem_sched.sv
// echo_mem_sched: per-frame L/R read-modify-write sequencer for the shared echo delay RAM.
// Ports: CLOCK_50/reset_n system clock and async active-low reset; ADCLRCK codec frame clock (sampled as data);
// leftSampleIn/rightSampleIn/delay_time/disabled frame inputs; ram_addr/ram_wdata/ram_we/ram_q RAM port;
// leftSampleOut/rightSampleOut echoed samples; frame_done output-update pulse; busy sequence active; overrun sticky missed edge.
module echo_mem_sched #(
  parameter int ADDR_W   = 15,
  parameter int RD_LAT   = 1,
  parameter int FB_SHIFT = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic                     ADCLRCK,
  input  logic signed [15:0]       leftSampleIn,
  input  logic signed [15:0]       rightSampleIn,
  input  logic        [ADDR_W-1:0] delay_time,
  input  logic                     disabled,
  output logic        [ADDR_W:0]   ram_addr,
  output logic signed [15:0]       ram_wdata,
  output logic                     ram_we,
  input  logic signed [15:0]       ram_q,
  output logic signed [15:0]       leftSampleOut,
  output logic signed [15:0]       rightSampleOut,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     overrun
);
  typedef enum logic [2:0] {IDLE, RD_L, WR_L, RD_R, WR_R, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] sync;
  logic start;
  logic [1:0] cnt;
  logic rd_last;
  logic [ADDR_W-1:0] ptr, dly;
  logic signed [15:0] in_l, in_r, tap_l, tap_r, mix_l, mix_r;
  logic dis;
  function automatic logic signed [15:0] sat16(input logic signed [15:0] a, input logic signed [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    // Overflow of the 17-bit sum shows up as disagreeing top two bits.
    return (s[16] ^ s[15]) ? (s[16] ? 16'sh8000 : 16'sh7fff) : $signed(s[15:0]);
  endfunction
  // sync[1:0] is the two-flop synchroniser, sync[2] holds the previous synchronised level.
  assign start   = sync[1] & ~sync[2];
  assign rd_last = cnt == 2'(RD_LAT);
  assign mix_l   = dis ? in_l : sat16(in_l, tap_l >>> FB_SHIFT);
  assign mix_r   = dis ? in_r : sat16(in_r, tap_r >>> FB_SHIFT);
  assign busy       = state != IDLE;
  assign frame_done = state == DONE;
  always_comb begin
    state_nx  = state;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (state)
      IDLE: state_nx = start ? RD_L : IDLE;
      RD_L: begin
        ram_addr = {1'b0, ptr};
        state_nx = rd_last ? WR_L : RD_L;
      end
      WR_L: begin
        ram_addr  = {1'b0, ptr};
        ram_we    = 1'b1;
        ram_wdata = mix_l;
        state_nx  = RD_R;
      end
      RD_R: begin
        ram_addr = {1'b1, ptr};
        state_nx = rd_last ? WR_R : RD_R;
      end
      WR_R: begin
        ram_addr  = {1'b1, ptr};
        ram_we    = 1'b1;
        ram_wdata = mix_r;
        state_nx  = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      sync           <= '0;
      cnt            <= '0;
      ptr            <= '0;
      dly            <= '0;
      dis            <= 1'b0;
      in_l           <= '0;
      in_r           <= '0;
      tap_l          <= '0;
      tap_r          <= '0;
      leftSampleOut  <= '0;
      rightSampleOut <= '0;
      overrun        <= 1'b0;
    end else begin
      state <= state_nx;
      sync  <= {sync[1:0], ADCLRCK};
      cnt   <= ((state == RD_L || state == RD_R) && !rd_last) ? cnt + 2'd1 : 2'd0;
      if (start && state != IDLE) overrun <= 1'b1;
      if (state == IDLE && start) begin
        in_l <= leftSampleIn;
        in_r <= rightSampleIn;
        dly  <= delay_time;
        dis  <= disabled;
        // A shrunk ring must not leave the pointer stranded beyond its new end.
        if (ptr > delay_time) ptr <= '0;
      end
      if (state == RD_L && rd_last) tap_l <= ram_q;
      if (state == RD_R && rd_last) tap_r <= ram_q;
      // Outputs load as DONE is entered so they are valid while frame_done is high.
      if (state == WR_R) begin
        leftSampleOut  <= mix_l;
        rightSampleOut <= mix_r;
      end
      if (state == DONE) ptr <= (ptr == dly) ? '0 : ptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_echo_mem_sched.sv
// tb_echo_mem_sched: randomized scoreboard bench for echo_mem_sched against a ring-buffer reference model.
`timescale 1ns/1ps
module tb_echo_mem_sched;
  localparam int AW = 15;
  localparam int LAT = 1;
  localparam int FB = 1;
  logic clk = 0, rst_n = 0, adc = 0, dis = 0;
  logic [15:0] lin = 0, rin = 0;
  logic [AW-1:0] dly = 0;
  logic [AW:0] ram_addr;
  logic [15:0] ram_wdata, ram_q, lout, rout;
  logic ram_we, frame_done, busy, overrun;
  echo_mem_sched #(.ADDR_W(AW), .RD_LAT(LAT), .FB_SHIFT(FB)) dut (
    .CLOCK_50(clk), .reset_n(rst_n), .ADCLRCK(adc),
    .leftSampleIn(lin), .rightSampleIn(rin), .delay_time(dly), .disabled(dis),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q),
    .leftSampleOut(lout), .rightSampleOut(rout), .frame_done(frame_done),
    .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  logic [15:0] mem [0:(1<<(AW+1))-1];
  always @(posedge clk) begin
    ram_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end
  logic [15:0] m_mem [0:1][0:(1<<AW)-1];
  int mptr = 0;
  logic [32:0] exp_wr[$];
  logic [31:0] exp_out[$];
  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] sat(input int v);
    return v > 32767 ? 16'h7fff : (v < -32768 ? 16'h8000 : 16'(v));
  endfunction
  task automatic model_frame(input logic [15:0] l, input logic [15:0] r, input int d, input logic ds);
    logic [15:0] in_s [2];
    logic [15:0] w [2];
    int t;
    in_s[0] = l;
    in_s[1] = r;
    if (mptr > d) mptr = 0;
    for (int ch = 0; ch < 2; ch++) begin
      t = int'($signed(m_mem[ch][mptr]));
      t = t >>> FB;
      w[ch] = ds ? in_s[ch] : sat(int'($signed(in_s[ch])) + t);
      exp_wr.push_back({17'(ch * (1 << AW) + mptr), w[ch]});
      m_mem[ch][mptr] = w[ch];
    end
    exp_out.push_back({w[0], w[1]});
    mptr = (mptr == d) ? 0 : mptr + 1;
  endtask
  task automatic scramble();
    lin = 16'($urandom);
    rin = 16'($urandom);
    dly = AW'($urandom_range(0, 31));
    dis = 1'($urandom);
  endtask
  task automatic run_frame(input logic [15:0] l, input logic [15:0] r, input int d, input logic ds);
    model_frame(l, r, d, ds);
    @(posedge clk); #1;
    lin = l; rin = r; dly = AW'(d); dis = ds; adc = 1;
    repeat (6) @(posedge clk);
    #1 scramble();
    repeat (6) @(posedge clk);
    #1 adc = 0;
    repeat (8) @(posedge clk);
  endtask
  logic prev_we = 0, prev_busy = 0, chk_en = 1;
  int busy_len = 0, n_done = 0;
  logic [15:0] last_l = 0, last_wl = 0;
  logic [AW:0] last_al = 0;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (frame_done) begin
        n_done++;
        if (exp_out.size() == 0) begin
          checks++; failures++;
          $display("FAIL out: unexpected frame_done got %0h_%0h expected none", lout, rout);
        end else chk("out", 33'({lout, rout}), 33'(exp_out.pop_front()));
        last_l = lout;
      end
      if (ram_we) begin
        chk("we_gap", 33'(prev_we), 33'(0));
        if (exp_wr.size() == 0) begin
          checks++; failures++;
          $display("FAIL write: unexpected write got %0h expected none", {ram_addr, ram_wdata});
        end else chk("write", {ram_addr, ram_wdata}, exp_wr.pop_front());
        if (!ram_addr[AW]) begin
          last_wl = ram_wdata;
          last_al = ram_addr;
        end
      end
      if (prev_busy && !busy) chk("busy_len", 33'(busy_len), 33'(2 * (2 + LAT) + 1));
    end
    busy_len  = busy ? busy_len + 1 : 0;
    prev_busy = busy;
    prev_we   = ram_we;
  end
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic found;
    for (int i = 0; i < (1 << (AW + 1)); i++) mem[i] = '0;
    for (int c = 0; c < 2; c++) for (int i = 0; i < (1 << AW); i++) m_mem[c][i] = '0;
    #12;
    chk("rst_we", 33'(ram_we), 33'(0));
    chk("rst_addr", 33'(ram_addr), 33'(0));
    chk("rst_outs", 33'({lout, rout}), 33'(0));
    chk("rst_flags", 33'({frame_done, busy, overrun}), 33'(0));
    @(posedge clk); #1 rst_n = 1;
    repeat (4) @(posedge clk);
    for (int f = 1; f <= 9; f++) begin
      run_frame(16'd1000, 16'hfc18, 3, 0);
      if (f == 4) chk("echo_f4", 33'(last_l), 33'(16'd1000));
      if (f == 5) chk("echo_f5", 33'(last_l), 33'(16'd1500));
      if (f == 9) chk("echo_f9", 33'(last_l), 33'(16'd1750));
    end
    run_frame(16'd30000, 16'd30000, 0, 0);
    run_frame(16'd30000, 16'd30000, 0, 0);
    chk("sat_pos", 33'(last_wl), 33'(16'h7fff));
    run_frame(16'h8ad0, 16'h8ad0, 0, 0);
    run_frame(16'h8ad0, 16'h8ad0, 0, 0);
    chk("sat_neg", 33'(last_wl), 33'(16'h8000));
    run_frame(16'hfffb, 16'hfffb, 2, 1);
    chk("bypass_out", 33'(last_l), 33'(16'hfffb));
    chk("bypass_wr", 33'(last_wl), 33'(16'hfffb));
    for (int f = 0; f < 3; f++) run_frame(16'd0, 16'd0, 2, 0);
    chk("reenable_tap", 33'(last_l), 33'(16'hfffd));
    n = 0;
    while (mptr != 10 && n < 30) begin
      run_frame(16'($urandom), 16'($urandom), 20, 0);
      n++;
    end
    chk("shrink_reach10", 33'(mptr), 33'(10));
    run_frame(16'($urandom), 16'($urandom), 4, 0);
    chk("shrink_ptr0", 33'(last_al), 33'(0));
    for (int f = 0; f < 5; f++) run_frame(16'($urandom), 16'($urandom), 4, 0);
    for (int f = 0; f < 40; f++)
      run_frame(16'($urandom), 16'($urandom), $urandom_range(0, 7), 1'($urandom_range(0, 4) == 0));
    chk("no_overrun_yet", 33'(overrun), 33'(0));
    n = n_done;
    model_frame(16'd1234, 16'd4321, 5, 0);
    @(posedge clk); #1;
    lin = 16'd1234; rin = 16'd4321; dly = AW'(5); dis = 0; adc = 1;
    repeat (2) @(posedge clk);
    #1 adc = 0;
    repeat (2) @(posedge clk);
    #1 adc = 1; scramble();
    repeat (8) @(posedge clk);
    #1 adc = 0;
    repeat (10) @(posedge clk);
    chk("overrun_one_frame", 33'(n_done - n), 33'(1));
    chk("overrun_set", 33'(overrun), 33'(1));
    run_frame(16'($urandom), 16'($urandom), 5, 0);
    chk("overrun_sticky", 33'(overrun), 33'(1));
    chk_en = 0;
    @(posedge clk); #1;
    lin = 16'd777; rin = 16'd888; dly = AW'(5); adc = 1;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (ram_we && !ram_addr[AW]) found = 1;
    end
    chk("reset_reach_wrl", 33'(found), 33'(1));
    #2 rst_n = 0;
    #1;
    chk("midrst_we", 33'(ram_we), 33'(0));
    chk("midrst_addr_data", {ram_addr, ram_wdata}, 33'(0));
    chk("midrst_outs", 33'({lout, rout}), 33'(0));
    chk("midrst_flags", 33'({frame_done, busy, overrun}), 33'(0));
    exp_wr.delete();
    exp_out.delete();
    mptr = 0;
    adc = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1;
    chk_en = 1;
    repeat (4) @(posedge clk);
    run_frame(16'd2000, 16'd3000, 6, 0);
    chk("post_reset_addr0", 33'(last_al), 33'(0));
    chk("drain", 33'(exp_wr.size() + exp_out.size()), 33'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
